enemy_draw_control: RTL and testbench

Control FSM that drives the enemy-sprite drawing datapath. It accepts one draw or erase request for a 4x4 block at a given (x, y) and sequences the datapath's load strobes and counter enable. It asserts `plot` for exactly the 16 cycles in which the datapath presents a valid pixel to the VGA adapter. It sits between game logic (enemy position and health/colour updates) and the datapath.

---
 rtl/enemy_draw_control.sv | 124 ++++++++++++
 tb/tb_enemy_draw_control.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/enemy_draw_control.sv
// Sequences one 4x4 enemy-sprite draw/erase through the drawing datapath.
// Every output is a register loaded from the decoded next state, so outputs line up with the state.
module enemy_draw_control #(
   parameter logic [2:0] BG_COLOUR = 3'b000
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       go,
   input  logic       erase,
   input  logic [6:0] x_in,
   input  logic [6:0] y_in,
   input  logic [2:0] colour_in,
   output logic [6:0] point,
   output logic [2:0] c_in,
   output logic       load_x,
   output logic       load_y,
   output logic       load_colour,
   output logic       enable,
   output logic       plot,
   output logic       ready,
   output logic       done
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD_X,
      LOAD_Y,
      DRAW,
      DONE
   } state_e;

   state_e     state_q, state_d;
   logic [3:0] count_q, count_d;
   logic [6:0] x_q, x_d;
   logic [6:0] y_q, y_d;
   logic [2:0] col_q, col_d;

   logic [6:0] point_d;
   logic [2:0] c_in_d;
   logic       load_x_d, load_y_d, load_colour_d, enable_d, plot_d, ready_d, done_d;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      x_d     = x_q;
      y_d     = y_q;
      col_d   = col_q;
      unique case (state_q)
         IDLE: begin
            // ready (not state) gates go, so the edge that first raises ready after reset ignores go
            if (ready && go) begin
               x_d     = x_in;
               y_d     = y_in;
               col_d   = erase ? BG_COLOUR : colour_in;
               state_d = LOAD_X;
            end
         end
         LOAD_X: state_d = LOAD_Y;
         LOAD_Y: begin
            count_d = '0;
            state_d = DRAW;
         end
         DRAW: begin
            count_d = count_q + 4'd1;
            if (count_q == 4'd15) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      load_x_d      = (state_d == LOAD_X);
      load_colour_d = (state_d == LOAD_X);
      load_y_d      = (state_d == LOAD_Y);
      enable_d      = (state_d == DRAW);
      plot_d        = (state_d == DRAW);
      done_d        = (state_d == DONE);
      ready_d       = (state_d == IDLE);
      point_d       = point;
      c_in_d        = c_in;
      if (state_d == LOAD_X) begin
         point_d = x_d;
         c_in_d  = col_d;
      end else if (state_d == LOAD_Y) begin
         point_d = y_d;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         count_q     <= '0;
         x_q         <= '0;
         y_q         <= '0;
         col_q       <= '0;
         point       <= '0;
         c_in        <= '0;
         load_x      <= 1'b0;
         load_y      <= 1'b0;
         load_colour <= 1'b0;
         enable      <= 1'b0;
         plot        <= 1'b0;
         ready       <= 1'b0;
         done        <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         x_q         <= x_d;
         y_q         <= y_d;
         col_q       <= col_d;
         point       <= point_d;
         c_in        <= c_in_d;
         load_x      <= load_x_d;
         load_y      <= load_y_d;
         load_colour <= load_colour_d;
         enable      <= enable_d;
         plot        <= plot_d;
         ready       <= ready_d;
         done        <= done_d;
      end
   end

endmodule

// File: tb/tb_enemy_draw_control.sv
// Randomized and directed bench for enemy_draw_control against a phase-count reference model.
module tb_enemy_draw_control;

   localparam logic [2:0] BG = 3'b000;

   logic       clock = 1'b0;
   logic       resetn;
   logic       go, erase;
   logic [6:0] x_in, y_in;
   logic [2:0] colour_in;
   logic [6:0] point;
   logic [2:0] c_in;
   logic       load_x, load_y, load_colour, enable, plot, ready, done;

   always #5 clock = ~clock;

   enemy_draw_control #(.BG_COLOUR(BG)) dut (
      .clock(clock), .resetn(resetn), .go(go), .erase(erase),
      .x_in(x_in), .y_in(y_in), .colour_in(colour_in),
      .point(point), .c_in(c_in), .load_x(load_x), .load_y(load_y),
      .load_colour(load_colour), .enable(enable), .plot(plot),
      .ready(ready), .done(done)
   );

   // Reference: phase 0 idle, 1 load x, 2 load y, 3..18 pixels, 19 done.
   int         phase;
   bit         seen_edge;
   logic [6:0] cx, cy, mp;
   logic [2:0] cc, mc;
   logic [3:0] dp_cnt;
   int         checks, errors;
   int         cyc, plot_cnt, done_cnt;
   int         done_at[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] dut_outs();
      return {15'd0, point, c_in, load_x, load_y, load_colour, enable, plot, ready, done};
   endfunction

   function automatic logic [31:0] exp_outs();
      logic pix;
      pix = (phase >= 3) && (phase <= 18);
      return {15'd0, mp, mc, phase == 1, phase == 2, phase == 1, pix, pix,
              (phase == 0) && seen_edge, phase == 19};
   endfunction

   task automatic model_reset();
      phase = 0; seen_edge = 0;
      cx = '0; cy = '0; cc = '0; mp = '0; mc = '0;
      dp_cnt = '0;
   endtask

   task automatic step();
      logic en_prev;
      en_prev = enable;
      @(posedge clock);
      if (resetn) begin
         if (en_prev) dp_cnt = dp_cnt + 4'd1;
         if (phase == 0) begin
            if (seen_edge && go) begin
               phase = 1;
               cx = x_in; cy = y_in;
               cc = erase ? BG : colour_in;
            end
            seen_edge = 1;
         end else if (phase == 19) begin
            phase = 0;
         end else begin
            phase++;
         end
         if (phase == 1) begin mp = cx; mc = cc; end
         else if (phase == 2) mp = cy;
      end
      #1;
      cyc++;
      chk("outs", dut_outs(), exp_outs());
      chk("rdy_plot", {31'd0, ready & plot}, 32'd0);
      if (plot) begin
         plot_cnt++;
         chk("pix_off", {28'd0, dp_cnt}, phase - 3);
      end
      if (done) begin
         done_cnt++;
         done_at.push_back(cyc);
      end
   endtask

   task automatic async_reset();
      #2 resetn = 1'b0;
      #1;
      model_reset();
      chk("rst_async", dut_outs(), 32'd0);
   endtask

   task automatic release_reset();
      step();
      step();
      #2 resetn = 1'b1;
   endtask

   task automatic idle_inputs();
      go = 0; erase = 0; x_in = '0; y_in = '0; colour_in = '0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int d0, p0, n;
      checks = 0; errors = 0; cyc = 0; plot_cnt = 0; done_cnt = 0;
      idle_inputs();
      resetn = 1'b0;
      model_reset();
      #3;
      chk("rst_outs", dut_outs(), 32'd0);
      release_reset();
      step();
      chk("ready_up", {31'd0, ready}, 32'd1);

      // Basic draw at (10,20) colour 4
      go = 1; x_in = 7'd10; y_in = 7'd20; colour_in = 3'b100;
      step();
      chk("lx_point", {25'd0, point}, 32'd10);
      chk("lx_cin", {29'd0, c_in}, 32'd4);
      go = 0;
      step();
      chk("ly_point", {25'd0, point}, 32'd20);
      p0 = plot_cnt; d0 = done_cnt;
      for (int i = 0; i < 18; i++) step();
      chk("plot16", plot_cnt - p0, 32'd16);
      chk("done1", done_cnt - d0, 32'd1);

      // Erase uses background colour
      go = 1; erase = 1; colour_in = 3'b111; x_in = 7'd50; y_in = 7'd60;
      step();
      chk("erase_cin", {29'd0, c_in}, {29'd0, BG});
      idle_inputs();
      p0 = plot_cnt;
      for (int i = 0; i < 20; i++) step();
      chk("erase_plot16", plot_cnt - p0, 32'd16);

      // go hammered during a block must not restart it
      go = 1; x_in = 7'd33; y_in = 7'd44; colour_in = 3'b010;
      step();
      d0 = done_cnt;
      for (int i = 0; i < 18; i++) begin
         x_in = 7'($urandom); y_in = 7'($urandom);
         step();
         if (plot) chk("hold_point", {25'd0, point}, 32'd44);
      end
      go = 0;
      for (int i = 0; i < 3; i++) step();
      chk("one_done", done_cnt - d0, 32'd1);

      // Reset at pixel 7, then a fresh block must start at offset 0
      go = 1; x_in = 7'd5; y_in = 7'd6; colour_in = 3'b011;
      step();
      go = 0;
      n = 0;
      while (phase != 10 && n < 30) begin step(); n++; end
      chk("reach_px7", phase, 32'd10);
      async_reset();
      release_reset();
      step();
      chk("ready_after_rst", {31'd0, ready}, 32'd1);
      go = 1; x_in = 7'd1; y_in = 7'd2;
      step();
      go = 0;
      p0 = plot_cnt;
      for (int i = 0; i < 20; i++) step();
      chk("post_rst_plot16", plot_cnt - p0, 32'd16);

      // go and erase held: three blocks, 20-cycle period
      go = 1; erase = 1;
      p0 = plot_cnt;
      done_at.delete();
      for (int i = 0; i < 60; i++) step();
      idle_inputs();
      chk("held_plot48", plot_cnt - p0, 32'd48);
      chk("held_dones", done_at.size(), 32'd3);
      for (int i = 1; i < done_at.size(); i++)
         chk("done_period", done_at[i] - done_at[i-1], 32'd20);
      step();

      // Randomized traffic with occasional asynchronous resets
      for (int i = 0; i < 3000; i++) begin
         go        = ($urandom_range(0, 3) == 0);
         erase     = $urandom_range(0, 1);
         x_in      = 7'($urandom);
         y_in      = 7'($urandom);
         colour_in = 3'($urandom);
         step();
         if ($urandom_range(0, 499) == 0) begin
            async_reset();
            release_reset();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
